mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter sharing the 8-to-1 `mux` between eight requesters. Each requester raises a request; the arbiter picks one fairly, drives the mux `select_input` with its index, and presents the selected data bit on `out` with `valid` for a bounded number of cycles. It sits in front of the existing `mux` module, which it instantiates, and lets several consumers time-share one selector.

## Interface

- `HOLD_MAX`, default 4: maximum cycles one grant may last. Legal range 1..8.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `req` input, 8 bits: request per requester; bit i is requester i.
- `data_input` input, 8 bits: data bit per requester, fed to the mux.
- `done` input, 1 bit: the current owner finishes this cycle; ignored unless `valid`.
- `grant` output, 8 bits: one-hot owner, or 0 when idle.
- `select` output, 3 bits: binary index of the owner, driven into mux `select_input`.
- `valid` output, 1 bit: high while a grant is active.
- `out` output, 1 bit: mux output `data_input[select]`, gated by `valid`.

## Operation

- State machine with two states, IDLE and BUSY. A 3-bit round-robin pointer `ptr` and a hold counter `cnt` complete the state.
- **IDLE:** `grant`=0 and `valid`=0.
  - If `req` is nonzero, the winner is the first set bit searching `ptr`, `ptr+1`, … with mod-8 wrap-around.
  - Register the winner into `grant` and `select`, set `cnt`=1, and go to BUSY.
- **BUSY:** `valid`=1 and `out` = `data_input[select]`. A release condition ends the grant:
  - `done`=1, or
  - `cnt`==`HOLD_MAX`, or
  - `req[select]`=0. This condition applies only when lock is compiled out; see Configuration.
- **On release:** `ptr` ← `select`+1 mod 8 (7 wraps to 0). Then go to IDLE. Otherwise `cnt` ← `cnt`+1.
- **Simultaneous release conditions:** treat them as a single release; no extra effect.
- **Requests during BUSY:** new requests from other requesters never preempt the owner.
- **Output gating:** `out` is 0 whenever `valid`=0, regardless of the mux.
- **Reset values:** `grant`=0, `select`=0, `valid`=0, `out`=0, `ptr`=0, `cnt`=0, and the state is IDLE.
- **Reset mid-grant:** a reset during BUSY abandons the grant immediately. There is no completion cycle.

## Timing

- **Request to grant:** 1 cycle. A request sampled at edge N produces `grant`/`valid` high after edge N.
- **Grant to release:** `grant` drops after the edge that samples the release condition.
- **Minimum gap:** at least one IDLE cycle between grants. Back-to-back ownership therefore costs `hold`+1 cycles.
- **Maximum ownership:** `HOLD_MAX` cycles of `valid` per grant.
- **Fairness:** worst-case wait for a requester that holds `req` is 7×(`HOLD_MAX`+1) cycles.
- **Output path:** `out` is combinational from `data_input` through the mux during BUSY. It is not registered.

## Configuration

- Macro: `MUX_ARB_LOCK_EN`.
- **Defined:** the grant is locked. Dropping `req[select]` does not release; only `done` or the `HOLD_MAX` timeout releases.
- **Undefined:** dropping `req[select]` while BUSY releases on that edge, with the same `ptr` update as `done`.

## Structure

- **Shared package/header:** constants `MUX_ARB_N`=8, `MUX_ARB_SEL_W`=3, and the state encodings `ST_IDLE`=0 and `ST_BUSY`=1.
- **Sub-module:** one instance of the existing `mux`, with `data_input` ← `data_input`, `select_input` ← `select`, and `out` gated by `valid`. No other sub-modules.
- **Winner search:** combinational rotate-priority logic inside this block.

## Test plan

- **Reset:** hold `reset`=1 for 2 cycles with `req`=8'hFF → all outputs 0. After release with `req`=8'hFF, first `grant`=8'h01 and `select`=0.
- **Round-robin:** `req`=8'h91 held, `done` pulsed on each grant's first cycle → grants 8'h01, 8'h10, 8'h80, 8'h01 in that order, each separated by one IDLE cycle.
- **Timeout:** `HOLD_MAX`=4, `req`=8'h04 held, `done`=0 → `valid` high for exactly 4 cycles, 1 IDLE cycle, then `grant`=8'h04 again.
- **Data path:** owner 5, `data_input`=8'h20 then 8'h00 → `out`=1 then 0. When idle, `out`=0 even with `data_input`=8'hFF.
- **Lock:** owner 3, drop `req[3]` on its second BUSY cycle.
  - With `MUX_ARB_LOCK_EN`: the grant holds until `done` or the timeout.
  - Without it: `grant` is 0 the next cycle and `ptr`=4.
- **Reset mid-grant:** assert `reset` while `grant`=8'h40 → next cycle all outputs 0 and `ptr`=0; the next grant follows from `ptr`=0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared constants and FSM state encoding for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;
    localparam int MUX_ARB_N = 8;
    localparam int MUX_ARB_SEL_W = 3;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// mux: 8-to-1 single-bit selector shared by the arbiter's requesters.
module mux (
    input  logic [7:0] data_input,
    input  logic [2:0] select_input,
    output logic       out
);
    assign out = data_input[select_input];
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the shared mux; define MUX_ARB_LOCK_EN to lock grants against req drops.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [MUX_ARB_N-1:0]     req,
    input  logic [MUX_ARB_N-1:0]     data_input,
    input  logic                     done,
    output logic [MUX_ARB_N-1:0]     grant,
    output logic [MUX_ARB_SEL_W-1:0] select,
    output logic                     valid,
    output logic                     out
);
    state_t                   state;
    logic [MUX_ARB_SEL_W-1:0] ptr;
    logic [MUX_ARB_SEL_W-1:0] win;
    logic [MUX_ARB_SEL_W-1:0] idx;
    logic [3:0]               cnt;
    logic                     found;
    logic                     rel;
    logic                     mux_out;
    always_comb begin
        found = 1'b0;
        win = ptr;
        idx = ptr;
        for (int k = 0; k < MUX_ARB_N; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
`ifdef MUX_ARB_LOCK_EN
    assign rel = done || cnt == 4'(HOLD_MAX);
`else
    assign rel = done || cnt == 4'(HOLD_MAX) || !req[select];
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
            select <= '0;
            valid <= 1'b0;
            ptr <= '0;
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (found) begin
                grant <= MUX_ARB_N'(1) << win;
                select <= win;
                valid <= 1'b1;
                cnt <= 4'd1;
                state <= ST_BUSY;
            end
        end else if (rel) begin
            ptr <= select + 3'd1;
            grant <= '0;
            valid <= 1'b0;
            state <= ST_IDLE;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end
    mux u_mux (
        .data_input  (data_input),
        .select_input(select),
        .out         (mux_out)
    );
    assign out = valid & mux_out;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed stimulus with a per-cycle reference model of the round-robin arbiter.
module tb_mux_rr_arbiter;
    localparam int HOLD = 4;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] data_input = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] select;
    logic       valid;
    logic       out;
    int total = 0;
    int bad = 0;
    bit started = 1'b0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_sel = 0;

    mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .data_input(data_input), .done(done),
        .grant(grant), .select(select), .valid(valid), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester at or after p, scanning with wrap-around; -1 when nobody asks.
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner <= -1;
            m_ptr <= 0;
            m_cnt <= 0;
            m_sel <= 0;
        end else if (m_owner < 0) begin
            if (req != 8'h00) begin
                m_owner <= pick(req, m_ptr);
                m_sel <= pick(req, m_ptr);
                m_cnt <= 1;
            end
        end else if (done || m_cnt == HOLD || (!LOCK && !req[m_owner])) begin
            m_owner <= -1;
            m_ptr <= (m_owner + 1) % 8;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_grant", 32'(grant), m_owner < 0 ? 32'h0 : 32'(1) << m_owner);
            chk("model_valid", 32'(valid), 32'(m_owner >= 0));
            chk("model_select", 32'(select), 32'(m_sel));
            chk("model_out", 32'(out), m_owner < 0 ? 32'h0 : 32'(data_input[m_owner]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rr_exp [4];
        rr_exp = '{8'h01, 8'h10, 8'h80, 8'h01};
        req = 8'hFF;
        tick();
        started = 1'b1;
        tick();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_select", 32'(select), 32'h0);
        chk("reset_out", 32'(out), 32'h0);
        reset = 1'b0;
        tick();
        chk("first_grant", 32'(grant), 32'h01);
        chk("first_select", 32'(select), 32'h0);
        // Round-robin over 0x91 starting from a fresh pointer, done held so each grant lasts one cycle.
        reset = 1'b1;
        req = 8'h00;
        tick();
        reset = 1'b0;
        req = 8'h91;
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
            tick();
            chk("rr_gap", 32'(grant), 32'h0);
        end
        done = 1'b0;
        req = 8'h04;
        tick();
        chk("to_grant", 32'(grant), 32'h04);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_valid_hi", 32'(valid), 32'h1);
        end
        tick();
        chk("to_valid_lo", 32'(valid), 32'h0);
        tick();
        chk("to_regrant", 32'(grant), 32'h04);
        req = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h20;
        data_input = 8'h20;
        tick();
        chk("dp_grant", 32'(grant), 32'h20);
        chk("dp_out1", 32'(out), 32'h1);
        data_input = 8'h00;
        #1;
        chk("dp_out0", 32'(out), 32'h0);
        req = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        data_input = 8'hFF;
        #1;
        chk("dp_idle_out", 32'(out), 32'h0);
        req = 8'h08;
        tick();
        chk("lk_grant", 32'(grant), 32'h08);
        tick();
        req = 8'h00;
        tick();
        if (LOCK) begin
            chk("lk_hold3", 32'(grant), 32'h08);
            tick();
            chk("lk_hold4", 32'(grant), 32'h08);
            tick();
            chk("lk_timeout", 32'(grant), 32'h0);
        end else begin
            chk("lk_drop", 32'(grant), 32'h0);
        end
        chk("lk_ptr", 32'(dut.ptr), 32'h4);
        req = 8'h40;
        tick();
        chk("mr_grant", 32'(grant), 32'h40);
        reset = 1'b1;
        tick();
        chk("mr_grant0", 32'(grant), 32'h0);
        chk("mr_valid0", 32'(valid), 32'h0);
        chk("mr_select0", 32'(select), 32'h0);
        chk("mr_out0", 32'(out), 32'h0);
        chk("mr_ptr0", 32'(dut.ptr), 32'h0);
        reset = 1'b0;
        req = 8'h41;
        tick();
        chk("mr_next", 32'(grant), 32'h01);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
